fpu_top: RTL and testbench

FPU_TOP -- requirements
Module: fpu_top

---
 rtl/fpu_top.sv | 217 +++++++++++++++++++++
 tb/tb_fpu_top.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpu_top.sv
// Single-precision add/sub/mul unit: operands captured on valid, result registered one cycle later.
// Define FPU_RNE_EN for round-to-nearest-even; the default build truncates (round toward zero).
module fpu_top (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   input  logic        valid,
   input  logic [1:0]  op_sel,
   output logic [31:0] result,
   output logic        ready
);

   localparam logic [1:0]  OP_ADD = 2'b00;
   localparam logic [1:0]  OP_SUB = 2'b01;
   localparam logic [1:0]  OP_MUL = 2'b10;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;
`ifdef FPU_RNE_EN
   localparam logic        RNE_EN = 1'b1;
`else
   localparam logic        RNE_EN = 1'b0;
`endif

   // m = {hidden, frac[22:0], guard, round, sticky}; a clear hidden bit means zero
   function automatic logic [31:0] pack_round(input logic s, input logic signed [9:0] e,
                                              input logic [26:0] m);
      logic [24:0]       r;
      logic signed [9:0] e_adj;
      logic              up;
      up = RNE_EN & m[2] & (m[1] | m[0] | m[3]);
      r  = {1'b0, m[26:3]} + {24'd0, up};
      if (r[24]) begin
         e_adj = e + 10'sd1;
         r     = {1'b0, r[24:1]};
      end else begin
         e_adj = e;
      end
      if (r[23] == 1'b0) begin
         pack_round = {s, 31'd0};
      end else if (e_adj >= 10'sd255) begin
         pack_round = {s, 8'hFF, 23'd0};
      end else if (e_adj <= 10'sd0) begin
         pack_round = {s, 31'd0};
      end else begin
         pack_round = {s, e_adj[7:0], r[22:0]};
      end
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd0;
      for (int i = 0; i < 27; i++) begin
         lzc27 = v[i] ? 5'(26 - i) : lzc27;
      end
   endfunction

   logic [31:0]       a_r, b_r;
   logic [1:0]        op_r;
   logic              vld_r;
   logic [31:0]       result_r;
   logic              ready_r;

   logic              sa_s, sb_add_s, mul_s_s;
   logic [7:0]        ea_s, eb_s;
   logic [23:0]       ma_s, mb_s;
   logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;

   logic              a_big_s, s_big_s, sticky_s;
   logic [7:0]        e_big_s, e_sm_s, shift_s;
   logic [23:0]       m_big_s, m_sm_s;
   logic [26:0]       sm_ext_s, m_al_s, dif_s, add_m_s;
   logic [27:0]       sum_s;
   logic [4:0]        lz_s;
   logic signed [9:0] add_e_s;
   logic [31:0]       add_res_s;

   logic [47:0]       prod_s;
   logic signed [9:0] mul_e_base_s, mul_e_s;
   logic [26:0]       mul_m_s;
   logic [31:0]       mul_res_s;
   logic [31:0]       res_s;

   // Operand unpack; denormals flush to zero by clearing the mantissa
   always_comb begin
      sa_s     = a_r[31];
      ea_s     = a_r[30:23];
      eb_s     = b_r[30:23];
      a_zero_s = (ea_s == 8'h00);
      b_zero_s = (eb_s == 8'h00);
      a_inf_s  = (ea_s == 8'hFF) && (a_r[22:0] == 23'd0);
      b_inf_s  = (eb_s == 8'hFF) && (b_r[22:0] == 23'd0);
      a_nan_s  = (ea_s == 8'hFF) && (a_r[22:0] != 23'd0);
      b_nan_s  = (eb_s == 8'hFF) && (b_r[22:0] != 23'd0);
      ma_s     = a_zero_s ? 24'd0 : {1'b1, a_r[22:0]};
      mb_s     = b_zero_s ? 24'd0 : {1'b1, b_r[22:0]};
      sb_add_s = b_r[31] ^ (op_r == OP_SUB);
      mul_s_s  = a_r[31] ^ b_r[31];
   end

   // Add/sub: align smaller magnitude, add or subtract, normalise, round
   always_comb begin
      a_big_s  = {ea_s, ma_s} >= {eb_s, mb_s};
      e_big_s  = a_big_s ? ea_s : eb_s;
      e_sm_s   = a_big_s ? eb_s : ea_s;
      m_big_s  = a_big_s ? ma_s : mb_s;
      m_sm_s   = a_big_s ? mb_s : ma_s;
      s_big_s  = a_big_s ? sa_s : sb_add_s;
      shift_s  = e_big_s - e_sm_s;
      sm_ext_s = {m_sm_s, 3'b000};
      sum_s    = 28'd0;
      dif_s    = 27'd0;
      lz_s     = 5'd0;
      if (shift_s >= 8'd27) begin
         m_al_s   = 27'd0;
         sticky_s = |sm_ext_s;
      end else begin
         m_al_s   = sm_ext_s >> shift_s;
         sticky_s = |(sm_ext_s & ~(27'h7FF_FFFF << shift_s));
      end
      m_al_s = {m_al_s[26:1], m_al_s[0] | sticky_s};
      if (sa_s == sb_add_s) begin
         sum_s = {1'b0, m_big_s, 3'b000} + {1'b0, m_al_s};
         if (sum_s[27]) begin
            add_m_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
            add_e_s = {2'b00, e_big_s} + 10'd1;
         end else begin
            add_m_s = sum_s[26:0];
            add_e_s = {2'b00, e_big_s};
         end
      end else begin
         dif_s   = {m_big_s, 3'b000} - m_al_s;
         lz_s    = lzc27(dif_s);
         add_m_s = dif_s << lz_s;
         add_e_s = {2'b00, e_big_s} - {5'd0, lz_s};
      end
      add_res_s = (add_m_s == 27'd0) ? 32'h0000_0000 : pack_round(s_big_s, add_e_s, add_m_s);
   end

   // Multiply: 48-bit mantissa product, one-bit normalisation, round
   always_comb begin
      prod_s       = {24'd0, ma_s} * {24'd0, mb_s};
      mul_e_base_s = {2'b00, ea_s} + {2'b00, eb_s} - 10'd127;
      if (prod_s[47]) begin
         mul_m_s = {prod_s[47:22], |prod_s[21:0]};
         mul_e_s = mul_e_base_s + 10'sd1;
      end else begin
         mul_m_s = {prod_s[46:21], |prod_s[20:0]};
         mul_e_s = mul_e_base_s;
      end
      mul_res_s = pack_round(mul_s_s, mul_e_s, mul_m_s);
   end

   // Special-operand override and operation select
   always_comb begin
      res_s = QNAN;
      case (op_r)
         OP_ADD, OP_SUB: begin
            if (a_nan_s || b_nan_s) begin
               res_s = QNAN;
            end else if (a_inf_s && b_inf_s) begin
               res_s = (sa_s == sb_add_s) ? {sa_s, 8'hFF, 23'd0} : QNAN;
            end else if (a_inf_s) begin
               res_s = {sa_s, 8'hFF, 23'd0};
            end else if (b_inf_s) begin
               res_s = {sb_add_s, 8'hFF, 23'd0};
            end else begin
               res_s = add_res_s;
            end
         end
         OP_MUL: begin
            if (a_nan_s || b_nan_s) begin
               res_s = QNAN;
            end else if ((a_inf_s || b_inf_s) && (a_zero_s || b_zero_s)) begin
               res_s = QNAN;
            end else if (a_inf_s || b_inf_s) begin
               res_s = {mul_s_s, 8'hFF, 23'd0};
            end else begin
               res_s = mul_res_s;
            end
         end
         default: res_s = QNAN;
      endcase
   end

   // Operand capture stage; only qualified edges load new operands
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_r   <= 32'd0;
         b_r   <= 32'd0;
         op_r  <= 2'b00;
         vld_r <= 1'b0;
      end else begin
         vld_r <= valid;
         if (valid) begin
            a_r  <= din1;
            b_r  <= din2;
            op_r <= op_sel;
         end
      end
   end

   // Result stage; result holds between operations
   always_ff @(posedge clk) begin
      if (!reset) begin
         result_r <= 32'd0;
         ready_r  <= 1'b0;
      end else begin
         ready_r <= vld_r;
         if (vld_r) begin
            result_r <= res_s;
         end
      end
   end

   assign result = result_r;
   assign ready  = ready_r;

endmodule

// File: tb/tb_fpu_top.sv
// Self-checking bench for fpu_top: directed vector table, reset corner cases, back-to-back stream.
module tb_fpu_top;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] din1, din2;
   logic        valid;
   logic [1:0]  op_sel;
   logic [31:0] result;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_top dut (
      .clk    (clk),
      .reset  (reset),
      .din1   (din1),
      .din2   (din2),
      .valid  (valid),
      .op_sel (op_sel),
      .result (result),
      .ready  (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 19;
   vec_t vt[NV];

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s #%0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   // Exact integer -> single conversion (|v| < 2^24)
   function automatic logic [31:0] int_to_f32(input int v);
      logic        s;
      logic [31:0] mag;
      logic [31:0] m;
      int          p;
      if (v == 0) return 32'h0000_0000;
      s   = (v < 0);
      mag = s ? 32'(-v) : 32'(v);
      p   = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      m = mag << (23 - p);
      return {s, 8'(127 + p), m[22:0]};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] exp, input int idx);
      @(negedge clk);
      din1 = a; din2 = b; op_sel = op; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0; din1 = $urandom; din2 = $urandom; op_sel = 2'($urandom_range(0, 3));
      check("ready_early", idx, {31'd0, ready}, 32'd0);
      @(negedge clk);
      check("ready_pulse", idx, {31'd0, ready}, 32'd1);
      check("result", idx, result, exp);
      @(negedge clk);
      check("ready_drop", idx, {31'd0, ready}, 32'd0);
      check("result_hold", idx, result, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rnd_exp;
      logic [31:0] exp_arr[32];
      int          ia, ib, iop, iv;

`ifdef FPU_RNE_EN
      rnd_exp = 32'h3F80_0002;
`else
      rnd_exp = 32'h3F80_0001;
`endif
      vt[0]  = '{32'h3FC0_0000, 32'h4010_0000, 2'b00, 32'h4070_0000}; // 1.5 + 2.25
      vt[1]  = '{32'h4040_0000, 32'h4000_0000, 2'b10, 32'h40C0_0000}; // 3 * 2
      vt[2]  = '{32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000}; // 1 - 1
      vt[3]  = '{32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000}; // inf + -inf
      vt[4]  = '{32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 32'h7F80_0000}; // overflow
      vt[5]  = '{32'h3F80_0000, 32'h4000_0000, 2'b11, 32'h7FC0_0000}; // reserved op
      vt[6]  = '{32'h3F80_0001, 32'h3380_0000, 2'b00, rnd_exp};       // half-ulp tie
      vt[7]  = '{32'h4000_0000, 32'h3F80_0000, 2'b01, 32'h3F80_0000}; // 2 - 1
      vt[8]  = '{32'h3F80_0000, 32'hBF80_0000, 2'b00, 32'h0000_0000}; // 1 + -1
      vt[9]  = '{32'h0000_0000, 32'h7F80_0000, 2'b10, 32'h7FC0_0000}; // 0 * inf
      vt[10] = '{32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000}; // NaN in
      vt[11] = '{32'hFF80_0000, 32'h3F80_0000, 2'b00, 32'hFF80_0000}; // -inf + 1
      vt[12] = '{32'h7F80_0000, 32'hC000_0000, 2'b10, 32'hFF80_0000}; // inf * -2
      vt[13] = '{32'h8000_0001, 32'h3F80_0000, 2'b10, 32'h8000_0000}; // -denormal * 1
      vt[14] = '{32'h0080_0000, 32'h0080_0000, 2'b10, 32'h0000_0000}; // underflow
      vt[15] = '{32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0000}; // denormal add
      vt[16] = '{32'h3F80_0000, 32'h4000_0000, 2'b01, 32'hBF80_0000}; // 1 - 2
      vt[17] = '{32'h3FC0_0000, 32'h3FC0_0000, 2'b10, 32'h4010_0000}; // 1.5 * 1.5
      vt[18] = '{32'hBFC0_0000, 32'hC010_0000, 2'b00, 32'hC070_0000}; // -1.5 + -2.25

      reset = 1'b0; valid = 1'b0; din1 = 32'd0; din2 = 32'd0; op_sel = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_result", 0, result, 32'h0000_0000);
      check("reset_ready", 0, {31'd0, ready}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].op, vt[i].exp, i);
      end

      // reset on the edge after valid discards the in-flight operation
      @(negedge clk);
      din1 = 32'h3FC0_0000; din2 = 32'h4010_0000; op_sel = 2'b00; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("inflight_ready", 0, {31'd0, ready}, 32'd0);
      check("inflight_result", 0, result, 32'h0000_0000);
      reset = 1'b1;
      @(negedge clk);
      check("inflight_ready2", 0, {31'd0, ready}, 32'd0);
      run_op(32'h4040_0000, 32'h4000_0000, 2'b10, 32'h40C0_0000, 100);

      // operation sampled together with reset is discarded
      @(negedge clk);
      din1 = 32'h4040_0000; din2 = 32'h4000_0000; op_sel = 2'b10; valid = 1'b1; reset = 1'b0;
      @(negedge clk);
      valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("same_edge_ready", 0, {31'd0, ready}, 32'd0);
      @(negedge clk);
      check("same_edge_ready2", 0, {31'd0, ready}, 32'd0);
      check("same_edge_result", 0, result, 32'h0000_0000);
      run_op(32'h3FC0_0000, 32'h4010_0000, 2'b00, 32'h4070_0000, 101);

      // back-to-back stream of exactly representable integer operations
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 33) begin
            check("b2b_ready", i - 2, {31'd0, ready}, 32'd1);
            check("b2b_result", i - 2, result, exp_arr[i - 2]);
         end
         if (i == 34) check("b2b_ready_end", 0, {31'd0, ready}, 32'd0);
         if (i < 32) begin
            ia  = int'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
            ib  = int'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
            iop = int'($urandom_range(0, 2));
            iv  = (iop == 0) ? ia + ib : (iop == 1) ? ia - ib : ia * ib;
            exp_arr[i] = int_to_f32(iv);
            din1 = int_to_f32(ia); din2 = int_to_f32(ib); op_sel = 2'(iop); valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
